double_da_out: RTL and testbench
================================

DOUBLE_DA_OUT -- requirements
Module: double_da_out

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, meaning sample-pair FIFO entries (power of two).
REQ-002 Parameter MIDSCALE, default 12'h800, meaning DAC code driven at reset (offset-binary zero).
REQ-003 Port clk  input  1  system clock; all logic synchronous to its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port address  input  2  Avalon-MM slave register select.
REQ-006 Port read  input  1  Avalon read strobe, zero wait states.
REQ-007 Port write  input  1  Avalon write strobe, zero wait states.
REQ-008 Port writedata  input  32  Avalon write data.
REQ-009 Port readdata  output  32  Avalon read data.
REQ-010 Port irq  output  1  level interrupt, FIFO low-water.
REQ-011 Port u_output  output  12  voltage-channel DAC code, registered.
REQ-012 Port i_output  output  12  current-channel DAC code, registered.
REQ-013 Port da_wr  output  1  one-clk strobe, high in the cycle u_output/i_output take a new value.

Function
REQ-014 Register map: 0 DATA (W: push {i=wd[27:16], u=wd[11:0]}; R: level), 1 CTRL (RW: bit0 enable, bit1 irq_en, bits[12:8] threshold), 2 DIV (RW: bits[15:0] rate divisor), 3 STATUS (R: bit0 empty, bit1 full, bit2 underrun, bit3 overflow, bits[8:4] level; W: 1 to bit2/bit3 clears that bit).
REQ-015 readdata combinational from address when read=1, 32'h0 when read=0; unused bits read 0.
REQ-016 FIFO stores 24-bit pairs; level 0..FIFO_DEPTH in 5 bits; pointers wrap modulo FIFO_DEPTH.
REQ-017 Write to DATA when full and no pop in the same cycle: data dropped, overflow set, level unchanged.
REQ-018 Push and pop in the same cycle: both occur, level unchanged, including at full.
REQ-019 Rate counter: held at 0 while enable=0; else counts 0..DIV, tick asserted in the cycle count==DIV, then returns to 0; DIV=0 gives tick every cycle.
REQ-020 Any write to DIV or any 0->1 transition of enable resets the counter to 0.
REQ-021 On tick with FIFO non-empty: pop head; next cycle u_output/i_output = popped pair and da_wr=1 (latency 1 clk from tick).
REQ-022 On tick with FIFO empty: underrun set, outputs hold last value, da_wr stays 0.
REQ-023 Clearing enable does not flush FIFO or change outputs; no pops occur while disabled.
REQ-024 irq = irq_en AND (level <= threshold), evaluated on registered level; a threshold of 0 fires only when empty.
REQ-025 Sticky-bit set and software clear in the same cycle: set wins.

Reset
REQ-026 While rst_n=0: u_output=i_output=MIDSCALE, da_wr=0, irq=0, FIFO empty (level 0), pointers 0, CTRL=0, DIV=0, counter 0, underrun=overflow=0.
REQ-027 Reset asserted mid-operation discards FIFO contents immediately; no da_wr pulse in the first cycle after release.

Verification
REQ-028 Reset release, no access -> u_output=i_output=12'h800, da_wr=0, irq=0, STATUS reads 32'h1.
REQ-029 DIV=3, push 0x0ABC_0123 and 0x0DEF_0456, enable=1 -> da_wr pulses every 4 clks; outputs u=0x123,i=0xABC then u=0x456,i=0xDEF; then underrun=1, outputs hold.
REQ-030 Push 17 pairs with enable=0 -> level=16, full=1, overflow=1; 17th pair never appears at outputs.
REQ-031 CTRL: irq_en=1, threshold=2; push 4, DIV=0, enable -> irq rises the cycle level reaches 2, stays high to empty, drops after a push taking level to 3.
REQ-032 Full FIFO, DIV=0, enable, write DATA every cycle -> level stays 16, no overflow, outputs follow pushed order.
REQ-033 rst_n low for one clk while streaming at level 8 -> level 0, outputs 12'h800 asynchronously, no da_wr until new pushes and ticks after enable is set again.

Source files
------------

// File: rtl/double_da_out.sv
// Dual-channel DAC sample streamer: Avalon-MM register file, sample-pair FIFO,
// programmable rate divider and registered DAC code outputs.
module double_da_out #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [11:0] MIDSCALE   = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [11:0] u_output,
  output logic [11:0] i_output,
  output logic        da_wr
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [11:0] i;
    logic [11:0] u;
  } pair_t;

  pair_t           mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  logic            ctrl_en;
  logic            ctrl_irq_en;
  logic [4:0]      ctrl_thr;
  logic [15:0]     div;
  logic [15:0]     cnt;
  logic            underrun;
  logic            overflow;

  logic            wr_data_c;
  logic            wr_ctrl_c;
  logic            wr_div_c;
  logic            wr_stat_c;
  logic            empty_c;
  logic            full_c;
  logic            tick_c;
  logic            pop_c;
  logic            push_c;
  logic            en_rise_c;
  pair_t           wr_pair_c;
  logic            unused_wd;

  assign wr_data_c = write && (address == 2'd0);
  assign wr_ctrl_c = write && (address == 2'd1);
  assign wr_div_c  = write && (address == 2'd2);
  assign wr_stat_c = write && (address == 2'd3);

  assign empty_c   = (level == '0);
  assign full_c    = (level == LW'(FIFO_DEPTH));
  assign tick_c    = ctrl_en && (cnt == div);
  assign pop_c     = tick_c && !empty_c;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign push_c    = wr_data_c && (!full_c || pop_c);
  assign en_rise_c = wr_ctrl_c && writedata[0] && !ctrl_en;

  assign wr_pair_c = '{i: writedata[27:16], u: writedata[11:0]};
  assign unused_wd = ^writedata[31:28];

  // Control and divisor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_thr    <= 5'd0;
      div         <= 16'd0;
    end else begin
      if (wr_ctrl_c) begin
        ctrl_en     <= writedata[0];
        ctrl_irq_en <= writedata[1];
        ctrl_thr    <= writedata[12:8];
      end
      if (wr_div_c) begin
        div <= writedata[15:0];
      end
    end
  end

  // Rate counter: restarts on divisor write or enable rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 16'd0;
    end else if (!ctrl_en || wr_div_c || en_rise_c || tick_c) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_pair_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky status flags; a hardware set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (tick_c && empty_c) begin
        underrun <= 1'b1;
      end else if (wr_stat_c && writedata[2]) begin
        underrun <= 1'b0;
      end
      if (wr_data_c && full_c && !pop_c) begin
        overflow <= 1'b1;
      end else if (wr_stat_c && writedata[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  // DAC output registers, updated one clock after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_output <= MIDSCALE;
      i_output <= MIDSCALE;
      da_wr    <= 1'b0;
    end else begin
      da_wr <= pop_c;
      if (pop_c) begin
        u_output <= mem[rd_ptr].u;
        i_output <= mem[rd_ptr].i;
      end
    end
  end

  // Low-water interrupt is a pure function of registered state.
  assign irq = ctrl_irq_en && (32'(level) <= 32'(ctrl_thr));

  always_comb begin
    readdata = 32'h0;
    if (read) begin
      case (address)
        2'd0:    readdata = 32'(level);
        2'd1:    readdata = {19'd0, ctrl_thr, 6'd0, ctrl_irq_en, ctrl_en};
        2'd2:    readdata = {16'd0, div};
        default: readdata = (32'(level) << 4) |
                            {28'd0, overflow, underrun, full_c, empty_c};
      endcase
    end
  end

endmodule

// File: tb/tb_double_da_out.sv
// Scoreboard bench for double_da_out: pushes queue expected DAC pairs, a
// monitor checks each da_wr strobe; directed register and timing checks.
module tb_double_da_out;

  logic        clk;
  logic        rst_n;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [11:0] u_output;
  logic [11:0] i_output;
  logic        da_wr;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          cyc = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;

  double_da_out dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq),
    .u_output  (u_output),
    .i_output  (i_output),
    .da_wr     (da_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Scoreboard monitor: every da_wr must deliver the oldest expected pair.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && da_wr === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_da_wr: got i=0x%0h u=0x%0h expected no strobe", i_output, u_output);
      end else begin
        mon_e = exp_q.pop_front();
        if ({i_output, u_output} === mon_e) pass_cnt++;
        else $display("FAIL dac_pair: got i=0x%0h u=0x%0h expected i=0x%0h u=0x%0h",
                      i_output, u_output, mon_e[23:12], mon_e[11:0]);
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    #1 d = readdata;
    read = 1'b0;
  endtask

  task automatic push_pair(input logic [11:0] iv, input logic [11:0] uv, input bit accept);
    if (accept) exp_q.push_back({iv, uv});
    bus_write(2'd0, {4'hF, iv, 4'hA, uv});
  endtask

  task automatic wait_da(input string nm, output int c);
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (da_wr) begin got = 1'b1; break; end
    end
    chk(nm, 32'(got), 32'd1);
    c = cyc;
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int c1, c2, nstb;
    logic exp_irq [6];
    exp_irq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b0; address = 2'd0; read = 1'b0; write = 1'b0; writedata = 32'h0;

    // Reset state
    #12;
    chk("rst_u", 32'(u_output), 32'h800);
    chk("rst_da_wr", 32'(da_wr), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_u", 32'(u_output), 32'h800);
    chk("post_rst_i", 32'(i_output), 32'h800);
    chk("post_rst_irq", 32'(irq), 32'h0);
    bus_read(2'd3, rd);
    chk("post_rst_status", rd, 32'h1);

    // Paced streaming with DIV=3 then underrun
    bus_write(2'd2, 32'd3);
    push_pair(12'hABC, 12'h123, 1'b1);
    push_pair(12'hDEF, 12'h456, 1'b1);
    bus_write(2'd1, 32'h1);
    wait_da("div3_first_strobe", c1);
    wait_da("div3_second_strobe", c2);
    chk("div3_period", 32'(c2 - c1), 32'd4);
    repeat (12) @(negedge clk);
    chk("hold_u", 32'(u_output), 32'h456);
    chk("hold_i", 32'(i_output), 32'hDEF);
    bus_read(2'd3, rd);
    chk("underrun_status", rd, 32'h5);
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'hC);
    bus_read(2'd3, rd);
    chk("status_cleared", rd, 32'h1);

    // Overflow: 17 pushes while disabled
    for (int k = 0; k < 17; k++) push_pair(12'h300 + 12'(k), 12'h400 + 12'(k), k < 16);
    bus_read(2'd3, rd);
    chk("full_status", rd, 32'h10A);
    bus_read(2'd0, rd);
    chk("full_level", rd, 32'd16);
    bus_write(2'd2, 32'd0);
    bus_write(2'd1, 32'h1);
    wait_drain("drain_after_overflow");
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'hC);
    bus_read(2'd3, rd);
    chk("status_cleared2", rd, 32'h1);

    // Low-water interrupt, threshold 2
    bus_write(2'd1, 32'h202);
    chk("irq_empty", 32'(irq), 32'h1);
    for (int k = 0; k < 4; k++) push_pair(12'h5A0 + 12'(k), 12'h0A5 + 12'(k), 1'b1);
    chk("irq_level4", 32'(irq), 32'h0);
    bus_write(2'd1, 32'h203);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("irq_drain%0d", k), 32'(irq), 32'(exp_irq[k]));
      @(negedge clk);
    end
    bus_write(2'd1, 32'h202);
    bus_write(2'd3, 32'hC);
    push_pair(12'h6B0, 12'h0B6, 1'b1);
    chk("irq_refill1", 32'(irq), 32'h1);
    push_pair(12'h6B1, 12'h0B7, 1'b1);
    chk("irq_refill2", 32'(irq), 32'h1);
    push_pair(12'h6B2, 12'h0B8, 1'b1);
    chk("irq_refill3", 32'(irq), 32'h0);

    // Push and pop every cycle at full
    for (int k = 0; k < 13; k++) push_pair(12'h700 + 12'(k), 12'h7F0 - 12'(k), 1'b1);
    bus_write(2'd1, 32'h1);
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({12'h900 + 12'(k), 12'hE00 + 12'(k)});
      address = 2'd0; read = 1'b1; write = 1'b1;
      writedata = {4'h0, 12'h900 + 12'(k), 4'h0, 12'hE00 + 12'(k)};
      #1 chk($sformatf("stream_level%0d", k), readdata, 32'd16);
      @(negedge clk);
    end
    write = 1'b0; read = 1'b0;
    bus_read(2'd3, rd);
    chk("stream_no_overflow", rd & 32'h8, 32'h0);
    wait_drain("drain_after_stream");
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'hC);

    // Reset asserted mid-stream
    for (int k = 0; k < 8; k++) push_pair(12'hB00 + 12'(k), 12'h0B0 + 12'(k), 1'b1);
    bus_write(2'd2, 32'd3);
    bus_write(2'd1, 32'h1);
    wait_da("pre_reset_strobe", c1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_u", 32'(u_output), 32'h800);
    chk("async_rst_i", 32'(i_output), 32'h800);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    bus_read(2'd3, rd);
    chk("rst_status", rd, 32'h1);
    bus_read(2'd1, rd);
    chk("rst_ctrl", rd, 32'h0);
    nstb = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (da_wr) nstb++;
    end
    chk("no_strobe_after_rst", 32'(nstb), 32'd0);
    push_pair(12'hC01, 12'h3C0, 1'b1);
    push_pair(12'hC02, 12'h3C1, 1'b1);
    bus_write(2'd2, 32'd1);
    bus_write(2'd1, 32'h1);
    wait_drain("drain_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
